// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment hex driver.
package seven_seg_pkg;

  // Segment pattern with every segment dark, before pin polarity is applied.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex digit to segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Scan phase of the current cycle.
  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment pattern (active-high segments).
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import seven_seg_pkg::*;

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed multi-digit hex display driver with anti-ghost blanking,
// frame-synchronous value update and leading-zero suppression.
module seven_seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYC      = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done,
  output logic                  pending
);
  import seven_seg_pkg::*;

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_SHOW    = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_POL     = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_POL     = {DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [6:0]        SEG_PIN_OFF = SEG_OFF ^ SEG_POL;
  localparam logic              DP_PIN_OFF  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  scan_state_t         state;
  logic                slot_end;
  logic                frame_wrap;
  logic                direct_write;
  logic [3:0]          nib;
  logic                nib_dp;
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic                suppress;
  logic [6:0]          hex_seg;

  // Scan phase is decoded from the live enable and the slot counter.
  always_comb begin
    state = IDLE;
    if (enable) begin
      state = (cnt < CNT_SHOW) ? BLANK : SHOW;
    end
  end

  assign slot_end     = (state != IDLE) && (cnt == CNT_LAST);
  assign frame_wrap   = slot_end && (idx == IDX_LAST);
  // In IDLE or on the frame-wrap edge nothing is being torn, so write through.
  assign direct_write = (state == IDLE) || frame_wrap;

  // Slot counter and digit index; both park at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= frame_wrap ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow/display double buffer; a newer load always wins over an older shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else if (load && direct_write) begin
      disp_val <= value;
      disp_dp  <= dp_in;
      pending  <= 1'b0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
      pending    <= 1'b1;
    end else if (pending && direct_write) begin
      disp_val <= shadow_val;
      disp_dp  <= shadow_dp;
      pending  <= 1'b0;
    end
  end

  // Select the nibble, decimal point and enable line of the scanned digit.
  always_comb begin
    nib    = 4'h0;
    nib_dp = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = disp_val[4*i +: 4];
        nib_dp    = disp_dp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // Mark digits in the unbroken run of zeros from the top; digit 0 always shows.
  always_comb begin
    zero_run = blank_lz;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (disp_val[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  assign suppress = |(lz_mask & onehot);

  hex_to_7seg u_hex (
    .nibble (nib),
    .seg    (hex_seg)
  );

  // Registered pins: polarity is applied last so "off" is the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_PIN_OFF;
      dp         <= DP_PIN_OFF;
      dig_en     <= DIG_POL;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (state == SHOW) begin
        seg    <= (suppress ? SEG_OFF : hex_seg) ^ SEG_POL;
        dp     <= nib_dp ^ SEG_ACTIVE_LOW;
        dig_en <= onehot ^ DIG_POL;
      end else begin
        seg    <= SEG_PIN_OFF;
        dp     <= DP_PIN_OFF;
        dig_en <= DIG_POL;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: directed loads push the expected
// per-digit slot contents; a monitor pops them at the start of each lit slot.
module tb_seven_seg_scan_driver;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 8;
  localparam int BLANK_CYC   = 2;
  localparam int SHOW_LEN    = REFRESH_DIV - BLANK_CYC;

  typedef struct {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_en;
  logic        frame_done, pending;

  logic        rst_n_b, enable_b, load_b;
  logic [6:0]  seg_b;
  logic        dp_b;
  logic [3:0]  dig_en_b;
  logic        frame_done_b, pending_b;

  int    errors = 0;
  int    checks = 0;
  slot_t exp_q[$];
  logic  mon_on = 1'b0;

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_CYC(BLANK_CYC),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .dig_en(dig_en),
    .frame_done(frame_done), .pending(pending)
  );

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_CYC(BLANK_CYC),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n_b), .enable(enable_b), .load(load_b), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .dig_en(dig_en_b),
    .frame_done(frame_done_b), .pending(pending_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: at each slot start pop one expectation; at each slot end check lit length.
  logic [3:0] prev_en = 4'h0;
  int         lit = 0;
  bit         started = 1'b0;
  always @(negedge clk) begin
    slot_t e;
    if (!mon_on) begin
      started = 1'b0;
    end else if (dig_en != 4'h0 && prev_en == 4'h0) begin
      started = 1'b1;
      if (exp_q.size() == 0) begin
        check("extra_slot", 32'(dig_en), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("slot_dig_en", 32'(dig_en), 32'(e.en));
        check("slot_seg", 32'(seg), 32'(e.seg));
        check("slot_dp", 32'(dp), 32'(e.dp));
      end
    end else if (dig_en == 4'h0 && prev_en != 4'h0 && started) begin
      check("lit_len", 32'(lit), 32'(SHOW_LEN));
    end
    if (dig_en != 4'h0) lit = (prev_en == 4'h0) ? 1 : lit + 1;
    prev_en = dig_en;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    check("frame_done_timeout", 32'(frame_done), 32'h1);
  endtask

  task automatic wait_en(input logic [3:0] t);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dig_en == t) return;
    end
    check("dig_en_timeout", 32'(dig_en), 32'(t));
  endtask

  // Expect the frame that starts after the next frame_done to show s0..s3.
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dps);
    wait_fd();
    exp_q.push_back('{en: 4'b0001, seg: s0, dp: dps[0]});
    exp_q.push_back('{en: 4'b0010, seg: s1, dp: dps[1]});
    exp_q.push_back('{en: 4'b0100, seg: s2, dp: dps[2]});
    exp_q.push_back('{en: 4'b1000, seg: s3, dp: dps[3]});
    mon_on = 1'b1;
    wait_fd();
    tick(2);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    mon_on = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
    value = 16'h0; dp_in = 4'h0;
    rst_n_b = 1'b0; enable_b = 1'b0; load_b = 1'b0;
    tick(3);

    check("rst_seg", 32'(seg), 32'h00);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_dig_en", 32'(dig_en), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);

    rst_n = 1'b1;
    tick(1);

    // Load while idle writes straight to the display.
    pulse_load(16'h1A3F, 4'h0);
    check("idle_load_pending", 32'(pending), 32'h0);
    enable = 1'b1;
    tick(1);
    check("rise_blank0", 32'(dig_en), 32'h0);
    tick(1);
    check("rise_blank1", 32'(dig_en), 32'h0);
    tick(1);
    check("rise_show_en", 32'(dig_en), 32'h1);
    check("rise_show_seg", 32'(seg), 32'h71);

    wait_fd();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) break;
    end
    check("frame_period", 32'(n), 32'd32);
    run_frame(7'h71, 7'h4F, 7'h77, 7'h06, 4'b0000);

    // Mid-frame load waits for the frame boundary.
    wait_en(4'b0100);
    pulse_load(16'h0005, 4'h0);
    check("mid_load_pending", 32'(pending), 32'h1);
    wait_en(4'b1000);
    check("mid_old_digit3", 32'(seg), 32'h06);
    run_frame(7'h6D, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    check("commit_pending_clear", 32'(pending), 32'h0);

    // Two loads in one frame: last one wins.
    pulse_load(16'h1111, 4'h0);
    check("first_load_pending", 32'(pending), 32'h1);
    tick(4);
    pulse_load(16'h2222, 4'h0);
    run_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000);

    // Load in the frame-wrap cycle bypasses the shadow.
    wait_fd();
    tick(31);
    pulse_load(16'h7B9C, 4'h0);
    check("wrap_align", 32'(frame_done), 32'h1);
    check("wrap_bypass_pending", 32'(pending), 32'h0);
    run_frame(7'h39, 7'h6F, 7'h7C, 7'h07, 4'b0000);

    // Leading-zero suppression.
    blank_lz = 1'b1;
    pulse_load(16'h0040, 4'b1000);
    run_frame(7'h3F, 7'h66, 7'h00, 7'h00, 4'b1000);
    pulse_load(16'h0000, 4'b0000);
    run_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);
    blank_lz = 1'b0;

    // Enable fall: dark next cycle, pending shadow commits, scan restarts at digit 0.
    pulse_load(16'h000E, 4'h0);
    check("pre_fall_pending", 32'(pending), 32'h1);
    wait_en(4'b0010);
    enable = 1'b0;
    tick(1);
    check("fall_dig_en", 32'(dig_en), 32'h0);
    check("fall_seg", 32'(seg), 32'h00);
    check("fall_pending", 32'(pending), 32'h0);
    enable = 1'b1;
    tick(3);
    check("reenable_dig_en", 32'(dig_en), 32'h1);
    check("reenable_seg", 32'(seg), 32'h79);

    // Inverted-polarity instance.
    check("b_rst_seg", 32'(seg_b), 32'h7F);
    check("b_rst_dp", 32'(dp_b), 32'h1);
    check("b_rst_dig_en", 32'(dig_en_b), 32'hF);
    check("b_rst_pending", 32'(pending_b), 32'h0);
    rst_n_b = 1'b1;
    enable_b = 1'b1;
    tick(3);
    check("b_show_dig_en", 32'(dig_en_b), 32'hE);
    check("b_show_seg", 32'(seg_b), 32'h40);
    tick(2);
    #2 rst_n_b = 1'b0;
    #1;
    check("b_async_seg", 32'(seg_b), 32'h7F);
    check("b_async_dp", 32'(dp_b), 32'h1);
    check("b_async_dig_en", 32'(dig_en_b), 32'hF);
    @(negedge clk);
    rst_n_b = 1'b1;
    tick(10);
    enable_b = 1'b0;
    tick(1);
    check("b_idle_seg", 32'(seg_b), 32'h7F);
    check("b_idle_dp", 32'(dp_b), 32'h1);
    check("b_idle_dig_en", 32'(dig_en_b), 32'hF);
    value = 16'h0008;
    dp_in = 4'h0;
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    check("b_idle_load_pending", 32'(pending_b), 32'h0);
    enable_b = 1'b1;
    tick(3);
    check("b_new_dig_en", 32'(dig_en_b), 32'hE);
    check("b_new_seg", 32'(seg_b), 32'h00);
    check("b_new_dp", 32'(dp_b), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
